data_memory_arbiter: RTL and testbench
======================================

# data_memory_arbiter

Two-port arbiter that shares the single-port `data_memory` (8 words × 32 bits, combinational read, negedge write) between requester A (CPU load/store stage) and requester B (debug/loader port). It latches one request per grant, drives the memory control and address lines from registers for a full clock cycle, and returns the read data, an acknowledge and an out-of-range error flag to the granted requester. Arbitration is round-robin.

## Interface
- `ADDR_WIDTH`, 32, requester and memory address width
- `DATA_WIDTH`, 32, data width
- `MEM_DEPTH`, 8, number of valid memory words; addresses `>= MEM_DEPTH` are out of range

- `clock_in`  in  1  system clock; all state changes on the rising edge
- `reset`  in  1  asynchronous, active-high reset
- `a_req`  in  1  requester A transaction request (level)
- `a_write`  in  1  1 = write, 0 = read
- `a_address`  in  ADDR_WIDTH  word address
- `a_writeData`  in  DATA_WIDTH  write data
- `a_ack`  out  1  one-cycle completion pulse
- `a_readData`  out  DATA_WIDTH  read result; held until the next A read completes
- `a_error`  out  1  valid with `a_ack`; 1 = address out of range
- `b_req`, `b_write`, `b_address`, `b_writeData`, `b_ack`, `b_readData`, `b_error`: same as the A signals, for requester B
- `address`  out  ADDR_WIDTH  to memory `address`
- `writeData`  out  DATA_WIDTH  to memory `writeData`
- `memWrite`  out  1  to memory `memWrite`
- `memRead`  out  1  to memory `memRead`
- `readData`  in  DATA_WIDTH  from memory `readData`
- `busy`  out  1  1 while in an ACCESS state

## Operation
- States: IDLE, ACCESS_A, ACCESS_B. `last_grant` is a 1-bit register (0 = A, 1 = B).
- Eligibility of port X at a rising edge: `x_req & ~x_ack & (state != ACCESS_X)`.
- Next-state rule, evaluated in every state at every rising edge:
  - Only one port eligible: go to its ACCESS state.
  - Both eligible: go to the port not equal to `last_grant`.
  - Neither eligible: go to IDLE.
- On the grant edge:
  - Latch the port's write, address and writeData into a command register.
  - Set `last_grant` to the granted port.
  - If the address is in range, register `memWrite` = write and `memRead` = ~write.
  - If the address is out of range, register both as 0.
  - `address` and `writeData` come from the command register.
- Leaving any state for a non-ACCESS state: `memWrite` = `memRead` = 0.
- On the edge that ends ACCESS_X:
  - `x_ack` <= 1 for exactly one cycle.
  - `x_error` <= out-of-range flag.
  - If read and in range: `x_readData` <= memory `readData`.
  - If read and out of range: `x_readData` <= 0.
  - Write: `x_readData` unchanged.
- The requester holds its request fields stable until it samples `x_ack`, and drops `x_req` in the ack cycle or the cycle after. Any request still held after that is a new transaction.
- Range check: `address < MEM_DEPTH`, compared on the full ADDR_WIDTH (no truncation).

## Timing
- Reset (asynchronous, any state, including mid-ACCESS):
  - State = IDLE, `last_grant` = 1 (A wins the first tie).
  - `memWrite` = `memRead` = 0, `address` = `writeData` = 0.
  - `a_ack` = `b_ack` = 0, `a_error` = `b_error` = 0, `a_readData` = `b_readData` = 0, `busy` = 0.
  - An interrupted transaction is dropped with no ack.
  - `memWrite` is 0 throughout reset, so memory reinitialisation is not disturbed.
- Latency: request sampled at edge E, ACCESS in cycle E..E+1, ack and data visible in cycle E+1..E+2.
- The memory write lands on the falling edge inside the ACCESS cycle; control lines are registered and stable for the whole cycle.
- A lone port gets at most one access per 3 cycles.
- Alternating ports run back to back: ACCESS_A → ACCESS_B with no idle cycle.
- Simultaneous `a_ack` and `b_ack` cannot occur.

## Test plan
- Reset, then A reads address 5: `memRead`=1, `address`=5 for one cycle; next cycle `a_ack`=1, `a_readData`=5, `a_error`=0.
- A writes 0xDEADBEEF to address 3, then B reads address 3: `memWrite` pulses for one cycle; later `b_ack` with `b_readData`=0xDEADBEEF; `a_readData` unchanged.
- A and B both request a read of address 2 from IDLE after reset: sequence ACCESS_A then ACCESS_B back to back; `a_ack` one cycle before `b_ack`; both return 2. On the next simultaneous request, B is served first.
- B writes to address 8: `memWrite`=`memRead`=0 throughout; `b_ack`=1 with `b_error`=1; a subsequent read of address 7 returns 7 (memory untouched).
- B holds `b_req` high continuously with A idle: grants every 3 cycles, `busy` pattern 1,0,0 repeating, exactly one `b_ack` per grant.
- Assert `reset` during ACCESS_A of a write: all outputs go to 0 immediately; no `a_ack`; after release, the first tie is granted to A.

Source files
------------

// File: rtl/data_memory_arbiter.sv
// rtl/data_memory_arbiter.sv - round-robin arbiter sharing one single-port data memory between two requesters
// Control and address lines toward the memory are registered so they are stable across the whole access cycle.
module data_memory_arbiter #(
  parameter int ADDR_WIDTH = 32,
  parameter int DATA_WIDTH = 32,
  parameter int MEM_DEPTH  = 8
) (
  input  logic                  clock_in,
  input  logic                  reset,
  input  logic                  a_req,
  input  logic                  a_write,
  input  logic [ADDR_WIDTH-1:0] a_address,
  input  logic [DATA_WIDTH-1:0] a_writeData,
  output logic                  a_ack,
  output logic [DATA_WIDTH-1:0] a_readData,
  output logic                  a_error,
  input  logic                  b_req,
  input  logic                  b_write,
  input  logic [ADDR_WIDTH-1:0] b_address,
  input  logic [DATA_WIDTH-1:0] b_writeData,
  output logic                  b_ack,
  output logic [DATA_WIDTH-1:0] b_readData,
  output logic                  b_error,
  output logic [ADDR_WIDTH-1:0] address,
  output logic [DATA_WIDTH-1:0] writeData,
  output logic                  memWrite,
  output logic                  memRead,
  input  logic [DATA_WIDTH-1:0] readData,
  output logic                  busy
);

  localparam logic [1:0] IDLE     = 2'd0;
  localparam logic [1:0] ACCESS_A = 2'd1;
  localparam logic [1:0] ACCESS_B = 2'd2;

  localparam logic [ADDR_WIDTH-1:0] DEPTH_LIMIT = ADDR_WIDTH'(MEM_DEPTH);

  logic [1:0] state;
  logic [1:0] nextState;
  logic       lastGrant;
  logic       cmdWrite;
  logic       cmdError;
  logic       aEligible;
  logic       bEligible;
  logic       aInRange;
  logic       bInRange;

  // A port that is being served or is still showing its ack cannot re-enter arbitration.
  assign aEligible = a_req & ~a_ack & (state != ACCESS_A);
  assign bEligible = b_req & ~b_ack & (state != ACCESS_B);
  assign aInRange  = a_address < DEPTH_LIMIT;
  assign bInRange  = b_address < DEPTH_LIMIT;
  assign busy      = (state != IDLE);

  always_comb begin
    nextState = IDLE;
    if (aEligible && bEligible) begin
      nextState = lastGrant ? ACCESS_A : ACCESS_B;
    end else if (aEligible) begin
      nextState = ACCESS_A;
    end else if (bEligible) begin
      nextState = ACCESS_B;
    end
  end

  always_ff @(posedge clock_in or posedge reset) begin
    if (reset) begin
      state      <= IDLE;
      lastGrant  <= 1'b1;
      cmdWrite   <= 1'b0;
      cmdError   <= 1'b0;
      address    <= '0;
      writeData  <= '0;
      memWrite   <= 1'b0;
      memRead    <= 1'b0;
      a_ack      <= 1'b0;
      a_error    <= 1'b0;
      a_readData <= '0;
      b_ack      <= 1'b0;
      b_error    <= 1'b0;
      b_readData <= '0;
    end else begin
      a_ack <= 1'b0;
      b_ack <= 1'b0;

      // Complete the transaction held in the command register.
      if (state == ACCESS_A) begin
        a_ack   <= 1'b1;
        a_error <= cmdError;
        if (!cmdWrite) begin
          a_readData <= cmdError ? '0 : readData;
        end
      end
      if (state == ACCESS_B) begin
        b_ack   <= 1'b1;
        b_error <= cmdError;
        if (!cmdWrite) begin
          b_readData <= cmdError ? '0 : readData;
        end
      end

      state <= nextState;
      case (nextState)
        ACCESS_A: begin
          lastGrant <= 1'b0;
          cmdWrite  <= a_write;
          cmdError  <= ~aInRange;
          address   <= a_address;
          writeData <= a_writeData;
          memWrite  <= aInRange & a_write;
          memRead   <= aInRange & ~a_write;
        end
        ACCESS_B: begin
          lastGrant <= 1'b1;
          cmdWrite  <= b_write;
          cmdError  <= ~bInRange;
          address   <= b_address;
          writeData <= b_writeData;
          memWrite  <= bInRange & b_write;
          memRead   <= bInRange & ~b_write;
        end
        default: begin
          memWrite <= 1'b0;
          memRead  <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_data_memory_arbiter.sv
// tb/tb_data_memory_arbiter.sv - self-checking bench for data_memory_arbiter
// Transaction-level reference model: memory image, per-port last read value and round-robin owner.
module tb_data_memory_arbiter;

  logic        clk;
  logic        reset;
  logic        a_req, a_write, a_ack, a_error;
  logic [31:0] a_address, a_writeData, a_readData;
  logic        b_req, b_write, b_ack, b_error;
  logic [31:0] b_address, b_writeData, b_readData;
  logic [31:0] address, writeData, readData;
  logic        memWrite, memRead, busy;

  int checks = 0;
  int failures = 0;

  data_memory_arbiter #(.ADDR_WIDTH(32), .DATA_WIDTH(32), .MEM_DEPTH(8)) dut (
    .clock_in(clk), .reset(reset),
    .a_req(a_req), .a_write(a_write), .a_address(a_address), .a_writeData(a_writeData),
    .a_ack(a_ack), .a_readData(a_readData), .a_error(a_error),
    .b_req(b_req), .b_write(b_write), .b_address(b_address), .b_writeData(b_writeData),
    .b_ack(b_ack), .b_readData(b_readData), .b_error(b_error),
    .address(address), .writeData(writeData), .memWrite(memWrite), .memRead(memRead),
    .readData(readData), .busy(busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Stand-in for data_memory: word i holds i after reset, combinational read, negedge write.
  logic [31:0] mem [8];
  always @(negedge clk or posedge reset) begin
    if (reset) begin
      for (int i = 0; i < 8; i++) mem[i] <= 32'(i);
    end else if (memWrite && address < 32'd8) begin
      mem[address[2:0]] <= writeData;
    end
  end
  assign readData = (address < 32'd8) ? mem[address[2:0]] : 32'd0;

  // Reference model state.
  logic [31:0] refMem [8];
  logic [31:0] expRdA, expRdB;
  logic        lastGrant;

  task automatic modelReset();
    for (int i = 0; i < 8; i++) refMem[i] = 32'(i);
    expRdA = 32'd0;
    expRdB = 32'd0;
    lastGrant = 1'b1;
  endtask

  task automatic modelAccess(input logic w, input logic [31:0] addr, input logic [31:0] data,
                             input logic [31:0] prevRd, output logic err, output logic [31:0] rd);
    err = (addr >= 32'd8);
    rd = prevRd;
    if (!err && w) refMem[addr[2:0]] = data;
    if (!w) rd = err ? 32'd0 : refMem[addr[2:0]];
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic checkAccess(input string tag, input logic w, input logic [31:0] addr, input logic [31:0] data);
    logic inRange;
    inRange = (addr < 32'd8);
    check({tag, " busy"}, 32'(busy), 32'd1);
    check({tag, " memRead"}, 32'(memRead), 32'(inRange & ~w));
    check({tag, " memWrite"}, 32'(memWrite), 32'(inRange & w));
    check({tag, " address"}, address, addr);
    if (w) check({tag, " writeData"}, writeData, data);
  endtask

  // One transaction per selected port, both raised on the same edge from an idle arbiter.
  task automatic txn(input logic useA, input logic aw, input logic [31:0] aaddr, input logic [31:0] adat,
                     input logic useB, input logic bw, input logic [31:0] baddr, input logic [31:0] bdat);
    int aAcc, bAcc;
    logic err;
    logic [31:0] rd;
    aAcc = 0;
    bAcc = 0;
    if (useA && useB) begin
      if (lastGrant) begin aAcc = 1; bAcc = 2; end
      else begin bAcc = 1; aAcc = 2; end
    end else if (useA) aAcc = 1;
    else if (useB) bAcc = 1;
    a_req = useA; a_write = aw; a_address = aaddr; a_writeData = adat;
    b_req = useB; b_write = bw; b_address = baddr; b_writeData = bdat;
    for (int c = 1; c <= 4; c++) begin
      step();
      if (c == aAcc) checkAccess("accessA", aw, aaddr, adat);
      else if (c == bAcc) checkAccess("accessB", bw, baddr, bdat);
      else begin
        check("idle busy", 32'(busy), 32'd0);
        check("idle memRead", 32'(memRead), 32'd0);
        check("idle memWrite", 32'(memWrite), 32'd0);
      end
      check("a_ack", 32'(a_ack), 32'(aAcc != 0 && c == aAcc + 1));
      check("b_ack", 32'(b_ack), 32'(bAcc != 0 && c == bAcc + 1));
      if (aAcc != 0 && c == aAcc + 1) begin
        modelAccess(aw, aaddr, adat, expRdA, err, rd);
        expRdA = rd;
        lastGrant = 1'b0;
        check("a_error", 32'(a_error), 32'(err));
        check("a_readData", a_readData, expRdA);
        a_req = 1'b0;
      end
      if (bAcc != 0 && c == bAcc + 1) begin
        modelAccess(bw, baddr, bdat, expRdB, err, rd);
        expRdB = rd;
        lastGrant = 1'b1;
        check("b_error", 32'(b_error), 32'(err));
        check("b_readData", b_readData, expRdB);
        b_req = 1'b0;
      end
    end
    a_req = 1'b0;
    b_req = 1'b0;
    check("a_readData held", a_readData, expRdA);
    check("b_readData held", b_readData, expRdB);
  endtask

  task automatic checkAllZero(input string tag);
    check({tag, " memWrite"}, 32'(memWrite), 32'd0);
    check({tag, " memRead"}, 32'(memRead), 32'd0);
    check({tag, " address"}, address, 32'd0);
    check({tag, " writeData"}, writeData, 32'd0);
    check({tag, " busy"}, 32'(busy), 32'd0);
    check({tag, " acks"}, {30'd0, a_ack, b_ack}, 32'd0);
    check({tag, " errors"}, {30'd0, a_error, b_error}, 32'd0);
    check({tag, " a_readData"}, a_readData, 32'd0);
    check({tag, " b_readData"}, b_readData, 32'd0);
  endtask

  initial begin
    logic useA, useB, aw, bw;
    logic [31:0] aaddr, baddr;
    reset = 1'b1;
    a_req = 0; a_write = 0; a_address = 0; a_writeData = 0;
    b_req = 0; b_write = 0; b_address = 0; b_writeData = 0;
    modelReset();
    step();
    step();
    checkAllZero("reset");
    reset = 1'b0;
    step();

    // A reads 5.
    txn(1, 0, 32'd5, 32'd0, 0, 0, 32'd0, 32'd0);
    // A writes DEADBEEF to 3, B reads it back.
    txn(1, 1, 32'd3, 32'hDEADBEEF, 0, 0, 32'd0, 32'd0);
    txn(0, 0, 32'd0, 32'd0, 1, 0, 32'd3, 32'd0);
    // Tie from idle after reset: A first, B back to back.
    txn(1, 0, 32'd2, 32'd0, 1, 0, 32'd2, 32'd0);
    // A alone, then a tie goes to B.
    txn(1, 0, 32'd1, 32'd0, 0, 0, 32'd0, 32'd0);
    txn(1, 0, 32'd6, 32'd0, 1, 0, 32'd6, 32'd0);
    // Out of range write, then memory untouched.
    txn(0, 0, 32'd0, 32'd0, 1, 1, 32'd8, 32'hCAFEF00D);
    txn(0, 0, 32'd0, 32'd0, 1, 0, 32'd7, 32'd0);
    // High address bits must not alias into range.
    txn(1, 0, 32'h0000_0103, 32'd0, 1, 1, 32'h8000_0001, 32'h1111_2222);
    txn(1, 0, 32'd1, 32'd0, 0, 0, 32'd0, 32'd0);

    // B held continuously: one grant every three cycles.
    b_req = 1'b1; b_write = 1'b0; b_address = 32'd4;
    for (int c = 1; c <= 9; c++) begin
      step();
      check("hold busy", 32'(busy), 32'(c % 3 == 1));
      check("hold b_ack", 32'(b_ack), 32'(c % 3 == 2));
      if (c % 3 == 2) check("hold b_readData", b_readData, refMem[4]);
    end
    b_req = 1'b0;
    expRdB = refMem[4];
    lastGrant = 1'b1;
    step();
    step();

    // Reset in the middle of an A write.
    a_req = 1'b1; a_write = 1'b1; a_address = 32'd4; a_writeData = 32'h1234_5678;
    step();
    check("pre-reset memWrite", 32'(memWrite), 32'd1);
    reset = 1'b1;
    #1;
    checkAllZero("midreset");
    a_req = 1'b0;
    step();
    check("reset no a_ack", 32'(a_ack), 32'd0);
    reset = 1'b0;
    modelReset();
    step();
    check("post-reset no a_ack", 32'(a_ack), 32'd0);
    txn(1, 0, 32'd4, 32'd0, 1, 0, 32'd4, 32'd0);

    // Randomized traffic against the model.
    for (int n = 0; n < 40; n++) begin
      useA = 1'($urandom_range(0, 1));
      useB = 1'($urandom_range(0, 1));
      if (!useA && !useB) useA = 1'b1;
      aw = 1'($urandom_range(0, 1));
      bw = 1'($urandom_range(0, 1));
      aaddr = ($urandom_range(0, 7) == 0) ? $urandom : 32'($urandom_range(0, 9));
      baddr = ($urandom_range(0, 7) == 0) ? $urandom : 32'($urandom_range(0, 9));
      txn(useA, aw, aaddr, $urandom, useB, bw, baddr, $urandom);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
